ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Consumer of the ID-stage control bundle produced by the instruction decoder. Carries it through ID/EX, EX/MEM and MEM/WB.
//  Resolves the destination register, detects load-use hazards and produces EX-stage forwarding selects.
//  Sits between the decoder and the datapath pipeline registers. Emits per-stage control only; data registers live elsewhere.
// PARAMETERS
//  RA_IDX   5'd31  register written by RegDst=2'b10 (link register)
// PORTS
//  clk              in   1  clock; all state updates on rising edge
//  reset            in   1  asynchronous, active-high; clears every register
//  id_valid         in   1  ID stage holds a real instruction
//  id_flush         in   1  kill the ID instruction (taken branch/jump); a bubble enters ID/EX
//  id_rs,id_rt,id_rd in  5  instruction register fields
//  id_reg_write     in   1  decoder RegWrite
//  id_reg_dst       in   2  00 rt, 01 rd, 10 RA_IDX, 11 rt
//  id_mem_read      in   1  decoder MemRead
//  id_mem_write     in   1  decoder MemWrite
//  id_mem_to_reg    in   2  decoder MemtoReg
//  id_alu_src1      in   1  decoder ALUSrc1
//  id_alu_src2      in   2  decoder ALUSrc2
//  id_alu_op        in   4  decoder ALUOp
//  id_branch        in   4  decoder Branch {branch,gt,lt,eq}
//  load_use_stall   out  1  comb: hold PC and IF/ID, bubble into ID/EX
//  ex_valid         out  1  EX instruction is real
//  ex_alu_src1/ex_alu_src2/ex_alu_op/ex_branch  out 1/2/4/4  registered EX controls
//  ex_dst           out  5  resolved destination in EX
//  fwd_a, fwd_b     out  2  EX operand select for rs/rt: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  mem_mem_read, mem_mem_write, mem_reg_write  out 1  registered MEM controls
//  mem_mem_to_reg   out  2 ; mem_dst out 5
//  wb_reg_write     out  1 ; wb_mem_to_reg out 2 ; wb_dst out 5
// BEHAVIOUR
//  - Reset (async, any time incl. mid-stream): every registered output and internal ex_rs/ex_rt/ex_mem_read/ex_reg_write/ex_mem_to_reg = 0.
//    Pipeline is all bubbles. fwd_a/fwd_b=00, load_use_stall=0 the same cycle.
//  - Destination: dst = reg_dst 01 ? rd : 10 ? RA_IDX : rt. It is resolved on ID->EX transfer.
//    If dst==0, reg_write is forced 0 in all later stages.
//  - Bubble = all controls 0, dst 0, valid 0. ID/EX loads a bubble when ~id_valid | id_flush | load_use_stall. Otherwise it loads the ID bundle.
//  - EX/MEM and MEM/WB advance unconditionally every cycle; no stage other than ID/EX ever holds or bubbles.
//  - Latency: bundle sampled at edge k -> ex_* valid after k; mem_* after k+1; wb_* after k+2.
//  - load_use_stall = id_valid & ~id_flush & ex_valid & ex_mem_read & ex_dst!=0 & (ex_dst==id_rs | ex_dst==id_rt).
//    Conservative: rt is compared even if unused. Flush wins over stall.
//    One stall cycle suffices: the next cycle the load is in MEM, EX holds a bubble, and the stall deasserts.
//  - fwd_a: 01 if mem_reg_write & mem_dst==ex_rs; else 10 if wb_reg_write & wb_dst==ex_rs; else 00.
//    fwd_b is the same against ex_rt. MEM has priority over WB. Register 0 never forwards (guaranteed by the forced reg_write).
//  - Forward from EX/MEM on a load cannot occur (the stall guarantees it); no check is required.
//  - No FSM beyond the three pipeline registers. All selects are combinational from registered state only, except load_use_stall, which also uses id_*.
// TESTING
//  1 Reset asserted mid-stream with three live instructions -> all outputs 0 immediately (async), then bubbles until new input.
//  2 add $3,$1,$2 (reg_dst=01, rd=3, reg_write=1) at edge 0 -> ex_dst=3 after e0, mem_dst=3/mem_reg_write=1 after e1, wb_dst=3 after e2.
//  3 lw $5,0($1), then add $6,$5,$2 -> load_use_stall=1 for exactly one cycle; EX gets a bubble; add reaches EX with fwd_a=10.
//  4 add $3,..; sub $4,$3,$3 back-to-back, older add $3 in WB -> fwd_a=fwd_b=01 (MEM priority over WB).
//  5 jal (reg_dst=10) -> ex_dst=31. An instruction with rd=0, reg_write=1 -> mem/wb_reg_write=0; a reader of $0 gets fwd=00.
//  6 id_flush=1 while load-use condition holds -> load_use_stall=0, ID/EX loads a bubble, ex_valid=0 next cycle.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Control pipeline from ID through WB.
// Resolves destinations, detects load-use hazards and drives EX forwarding selects.
module ctrl_pipe #(
  parameter logic [4:0] RA_IDX = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic       id_flush,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic [1:0] id_reg_dst,
  input  logic       id_mem_read,
  input  logic       id_mem_write,
  input  logic [1:0] id_mem_to_reg,
  input  logic       id_alu_src1,
  input  logic [1:0] id_alu_src2,
  input  logic [3:0] id_alu_op,
  input  logic [3:0] id_branch,
  output logic       load_use_stall,
  output logic       ex_valid,
  output logic       ex_alu_src1,
  output logic [1:0] ex_alu_src2,
  output logic [3:0] ex_alu_op,
  output logic [3:0] ex_branch,
  output logic [4:0] ex_dst,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_mem_read,
  output logic       mem_mem_write,
  output logic       mem_reg_write,
  output logic [1:0] mem_mem_to_reg,
  output logic [4:0] mem_dst,
  output logic       wb_reg_write,
  output logic [1:0] wb_mem_to_reg,
  output logic [4:0] wb_dst
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memToReg;
    logic       aluSrc1;
    logic [1:0] aluSrc2;
    logic [3:0] aluOp;
    logic [3:0] branch;
  } idEx_t;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memToReg;
    logic [4:0] dst;
  } exMem_t;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] memToReg;
    logic [4:0] dst;
  } memWb_t;

  idEx_t  exQ;
  idEx_t  exD;
  exMem_t memQ;
  memWb_t wbQ;
  logic [4:0] idDst;

  // Destination select from RegDst
  always_comb begin
    idDst = id_rt;
    unique case (id_reg_dst)
      2'b01:   idDst = id_rd;
      2'b10:   idDst = RA_IDX;
      default: idDst = id_rt;
    endcase
  end

  // Load in EX feeding the ID instruction; rt compared even if unused
  assign load_use_stall = id_valid & ~id_flush
                        & exQ.valid & exQ.memRead
                        & (exQ.dst != 5'd0)
                        & ((exQ.dst == id_rs) | (exQ.dst == id_rt));

  // Next ID/EX contents: bubble unless a live, unstalled instruction
  always_comb begin
    exD = '0;
    if (id_valid & ~id_flush & ~load_use_stall) begin
      exD.valid    = 1'b1;
      exD.rs       = id_rs;
      exD.rt       = id_rt;
      exD.dst      = idDst;
      exD.regWrite = id_reg_write & (idDst != 5'd0);
      exD.memRead  = id_mem_read;
      exD.memWrite = id_mem_write;
      exD.memToReg = id_mem_to_reg;
      exD.aluSrc1  = id_alu_src1;
      exD.aluSrc2  = id_alu_src2;
      exD.aluOp    = id_alu_op;
      exD.branch   = id_branch;
    end
  end

  // Pipeline registers; later stages advance every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exQ  <= '0;
      memQ <= '0;
      wbQ  <= '0;
    end else begin
      exQ           <= exD;
      memQ.regWrite <= exQ.regWrite;
      memQ.memRead  <= exQ.memRead;
      memQ.memWrite <= exQ.memWrite;
      memQ.memToReg <= exQ.memToReg;
      memQ.dst      <= exQ.dst;
      wbQ.regWrite  <= memQ.regWrite;
      wbQ.memToReg  <= memQ.memToReg;
      wbQ.dst       <= memQ.dst;
    end
  end

  // Forwarding selects; MEM has priority over WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (memQ.regWrite && memQ.dst == exQ.rs)
      fwd_a = 2'b01;
    else if (wbQ.regWrite && wbQ.dst == exQ.rs)
      fwd_a = 2'b10;
    if (memQ.regWrite && memQ.dst == exQ.rt)
      fwd_b = 2'b01;
    else if (wbQ.regWrite && wbQ.dst == exQ.rt)
      fwd_b = 2'b10;
  end

  assign ex_valid       = exQ.valid;
  assign ex_alu_src1    = exQ.aluSrc1;
  assign ex_alu_src2    = exQ.aluSrc2;
  assign ex_alu_op      = exQ.aluOp;
  assign ex_branch      = exQ.branch;
  assign ex_dst         = exQ.dst;
  assign mem_mem_read   = memQ.memRead;
  assign mem_mem_write  = memQ.memWrite;
  assign mem_reg_write  = memQ.regWrite;
  assign mem_mem_to_reg = memQ.memToReg;
  assign mem_dst        = memQ.dst;
  assign wb_reg_write   = wbQ.regWrite;
  assign wb_mem_to_reg  = wbQ.memToReg;
  assign wb_dst         = wbQ.dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios then random traffic.
// Reference keeps a history of what entered EX each cycle.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_reg_write;
  logic [1:0] id_reg_dst;
  logic       id_mem_read, id_mem_write;
  logic [1:0] id_mem_to_reg;
  logic       id_alu_src1;
  logic [1:0] id_alu_src2;
  logic [3:0] id_alu_op, id_branch;
  logic       load_use_stall, ex_valid, ex_alu_src1;
  logic [1:0] ex_alu_src2;
  logic [3:0] ex_alu_op, ex_branch;
  logic [4:0] ex_dst;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_mem_read, mem_mem_write, mem_reg_write;
  logic [1:0] mem_mem_to_reg;
  logic [4:0] mem_dst;
  logic       wb_reg_write;
  logic [1:0] wb_mem_to_reg;
  logic [4:0] wb_dst;

  ctrl_pipe dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_reg_dst(id_reg_dst),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src1(id_alu_src1),
    .id_alu_src2(id_alu_src2), .id_alu_op(id_alu_op),
    .id_branch(id_branch), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_alu_src1(ex_alu_src1),
    .ex_alu_src2(ex_alu_src2), .ex_alu_op(ex_alu_op),
    .ex_branch(ex_branch), .ex_dst(ex_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_dst(mem_dst), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs, rt, dst;
    logic       rw, mr, mw;
    logic [1:0] m2r;
    logic       as1;
    logic [1:0] as2;
    logic [3:0] op, br;
  } rec_t;

  rec_t hist[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setIn(logic v, logic fl, logic [4:0] rs, logic [4:0] rt,
                       logic [4:0] rd, logic rw, logic [1:0] rdst, logic mr);
    id_valid      = v;
    id_flush      = fl;
    id_rs         = rs;
    id_rt         = rt;
    id_rd         = rd;
    id_reg_write  = rw;
    id_reg_dst    = rdst;
    id_mem_read   = mr;
    id_mem_write  = 1'($urandom);
    id_mem_to_reg = 2'($urandom);
    id_alu_src1   = 1'($urandom);
    id_alu_src2   = 2'($urandom);
    id_alu_op     = 4'($urandom);
    id_branch     = 4'($urandom);
  endtask

  function automatic logic expStall(rec_t ex);
    return id_valid && !id_flush && ex.valid && ex.mr && ex.dst != 0
           && (ex.dst == id_rs || ex.dst == id_rt);
  endfunction

  function automatic logic [1:0] fwdExp(logic [4:0] src, rec_t m, rec_t w);
    if (m.rw && m.dst == src) return 2'b01;
    if (w.rw && w.dst == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic clearModel();
    hist = {};
    repeat (3) hist.push_front(rec_t'(0));
  endtask

  task automatic checkAll();
    rec_t e, m, w;
    e = hist[0];
    m = hist[1];
    w = hist[2];
    chk("stall", 32'(load_use_stall), 32'(expStall(e)));
    chk("ex", 32'({ex_valid, ex_alu_src1, ex_alu_src2, ex_alu_op,
                   ex_branch, ex_dst}),
        32'({e.valid, e.as1, e.as2, e.op, e.br, e.dst}));
    chk("mem", 32'({mem_mem_read, mem_mem_write, mem_reg_write,
                    mem_mem_to_reg, mem_dst}),
        32'({m.mr, m.mw, m.rw, m.m2r, m.dst}));
    chk("wb", 32'({wb_reg_write, wb_mem_to_reg, wb_dst}),
        32'({w.rw, w.m2r, w.dst}));
    chk("fwd_a", 32'(fwd_a), 32'(fwdExp(e.rs, m, w)));
    chk("fwd_b", 32'(fwd_b), 32'(fwdExp(e.rt, m, w)));
  endtask

  task automatic tick();
    rec_t n;
    logic st;
    #4;
    checkAll();
    st = expStall(hist[0]);
    @(posedge clk);
    n = '0;
    if (id_valid && !id_flush && !st) begin
      n.valid = 1'b1;
      n.rs    = id_rs;
      n.rt    = id_rt;
      n.dst   = (id_reg_dst == 2'b01) ? id_rd :
                (id_reg_dst == 2'b10) ? 5'd31 : id_rt;
      n.rw    = id_reg_write && n.dst != 0;
      n.mr    = id_mem_read;
      n.mw    = id_mem_write;
      n.m2r   = id_mem_to_reg;
      n.as1   = id_alu_src1;
      n.as2   = id_alu_src2;
      n.op    = id_alu_op;
      n.br    = id_branch;
    end
    hist.push_front(n);
    void'(hist.pop_back());
    #1;
  endtask

  initial begin
    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    clearModel();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
    checkAll();

    // add $3,$1,$2 latency
    setIn(1, 0, 1, 2, 3, 1, 2'b01, 0);
    tick();
    chk("t2_ex_dst", 32'(ex_dst), 3);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t2_mem_dst", 32'({mem_reg_write, mem_dst}), 32'h23);
    tick();
    chk("t2_wb_dst", 32'({wb_reg_write, wb_dst}), 32'h23);

    // lw $5 then add $6,$5,$2
    setIn(1, 0, 1, 5, 0, 1, 2'b00, 1);
    tick();
    setIn(1, 0, 5, 2, 6, 1, 2'b01, 0);
    #3;
    chk("t3_stall_on", 32'(load_use_stall), 1);
    tick();
    chk("t3_bubble", 32'(ex_valid), 0);
    #3;
    chk("t3_stall_off", 32'(load_use_stall), 0);
    tick();
    chk("t3_ex_dst", 32'(ex_dst), 6);
    chk("t3_fwd_a", 32'(fwd_a), 2);
    chk("t3_fwd_b", 32'(fwd_b), 0);

    // two writers of $3, then sub $4,$3,$3
    setIn(1, 0, 1, 2, 3, 1, 2'b01, 0);
    tick();
    tick();
    setIn(1, 0, 3, 3, 4, 1, 2'b01, 0);
    tick();
    chk("t4_fwd_a", 32'(fwd_a), 1);
    chk("t4_fwd_b", 32'(fwd_b), 1);

    // jal, writer of $0, reader of $0
    setIn(1, 0, 0, 0, 0, 1, 2'b10, 0);
    tick();
    chk("t5_jal_dst", 32'(ex_dst), 31);
    setIn(1, 0, 1, 2, 0, 1, 2'b01, 0);
    tick();
    setIn(1, 0, 0, 0, 5, 1, 2'b01, 0);
    tick();
    chk("t5_mem_rw0", 32'(mem_reg_write), 0);
    chk("t5_fwd0", 32'({fwd_a, fwd_b}), 0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_wb_rw0", 32'(wb_reg_write), 0);

    // flush beats stall
    setIn(1, 0, 1, 7, 0, 1, 2'b00, 1);
    tick();
    setIn(1, 1, 7, 7, 8, 1, 2'b01, 0);
    #3;
    chk("t6_stall", 32'(load_use_stall), 0);
    tick();
    chk("t6_bubble", 32'(ex_valid), 0);

    // async reset with three live instructions
    setIn(1, 0, 1, 2, 9, 1, 2'b01, 0);
    tick();
    setIn(1, 0, 3, 4, 10, 1, 2'b01, 1);
    tick();
    setIn(1, 0, 10, 4, 11, 1, 2'b01, 0);
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("t1_ex0", 32'({ex_valid, ex_alu_src1, ex_alu_src2, ex_alu_op,
                       ex_branch, ex_dst}), 0);
    chk("t1_mem0", 32'({mem_mem_read, mem_mem_write, mem_reg_write,
                        mem_mem_to_reg, mem_dst}), 0);
    chk("t1_wb0", 32'({wb_reg_write, wb_mem_to_reg, wb_dst}), 0);
    chk("t1_sel0", 32'({fwd_a, fwd_b, load_use_stall}), 0);
    clearModel();
    @(posedge clk);
    #1;
    reset = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // random traffic on a small register window
    repeat (400) begin
      setIn(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom),
            2'($urandom), 1'($urandom_range(0, 2) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
